// File: rtl/sincronizador_vga_pkg.sv
// Shared VGA timing package: default 640x480@60 constants, derived totals and
// sync windows, plus helpers so pixel-generation blocks derive the same values.
package sincronizador_vga_pkg;

    localparam int unsigned CNT_W = 10;

    typedef logic [CNT_W-1:0] pix_t;

    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    // Total period of one axis (line or frame) in counts.
    function automatic int unsigned timing_total(input int unsigned disp, input int unsigned front,
                                                 input int unsigned sync, input int unsigned back);
        return disp + front + sync + back;
    endfunction

    // First count of the sync pulse.
    function automatic int unsigned sync_start(input int unsigned disp, input int unsigned front);
        return disp + front;
    endfunction

    // Last count of the sync pulse (inclusive).
    function automatic int unsigned sync_end(input int unsigned disp, input int unsigned front,
                                             input int unsigned sync);
        return disp + front + sync - 1;
    endfunction

    localparam int unsigned H_TOTAL_DEF =
        timing_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int unsigned V_TOTAL_DEF =
        timing_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
    localparam int unsigned HS_START_DEF = sync_start(H_DISPLAY_DEF, H_FRONT_DEF);
    localparam int unsigned HS_END_DEF   = sync_end(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF);
    localparam int unsigned VS_START_DEF = sync_start(V_DISPLAY_DEF, V_FRONT_DEF);
    localparam int unsigned VS_END_DEF   = sync_end(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF);

endpackage

// File: rtl/sincronizador_vga_if.sv
// VGA timing bundle.
// master: driven by sincronizador_vga; slave: consumed by pixel generators.
//   hsync/vsync (active low), video_on, pixel_x/pixel_y, line_tick, frame_tick
interface sincronizador_vga_if;
    import sincronizador_vga_pkg::*;

    logic hsync;
    logic vsync;
    logic video_on;
    pix_t pixel_x;
    pix_t pixel_y;
    logic line_tick;
    logic frame_tick;

    modport master (
        output hsync, vsync, video_on, pixel_x, pixel_y, line_tick, frame_tick
    );

    modport slave (
        input hsync, vsync, video_on, pixel_x, pixel_y, line_tick, frame_tick
    );
endinterface

// File: rtl/sincronizador_vga_contador_mod.sv
// Mod-N counter with enable and synchronous reset to N-1.
//   clk, reset (sync, active high), en_i
//   count_o      : registered count
//   count_next_c : value the count takes at the next edge when reset is low
//   wrap_c       : count is N-1 and enabled, so it returns to 0 next edge
module contador_mod #(
    parameter int unsigned N = 800,
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_next_c,
    output logic         wrap_c
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next-count logic; reset is handled in the register.
    always_comb begin
        count_d = count_q;
        wrap_c  = en_i && (count_q == LAST);
        if (wrap_c) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= LAST;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_c = count_d;

endmodule

// File: rtl/sincronizador_vga.sv
// VGA sync generator: free-running horizontal/vertical counters with
// registered sync, blanking and tick outputs aligned to pixel_x/pixel_y.
//   clk   : pixel clock
//   reset : synchronous, active high; parks counters at the last pixel of a frame
//   vga   : timing outputs (master modport)
module sincronizador_vga
    import sincronizador_vga_pkg::*;
#(
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    sincronizador_vga_if.master  vga
);

    localparam int unsigned H_TOTAL = timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = timing_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam pix_t HS_START = pix_t'(sync_start(H_DISPLAY, H_FRONT));
    localparam pix_t HS_END   = pix_t'(sync_end(H_DISPLAY, H_FRONT, H_SYNC));
    localparam pix_t VS_START = pix_t'(sync_start(V_DISPLAY, V_FRONT));
    localparam pix_t VS_END   = pix_t'(sync_end(V_DISPLAY, V_FRONT, V_SYNC));
    localparam pix_t H_VIS    = pix_t'(H_DISPLAY);
    localparam pix_t V_VIS    = pix_t'(V_DISPLAY);

    pix_t x_q, x_next;
    pix_t y_q, y_next;
    logic h_wrap, v_wrap;

    logic hsync_q,      hsync_d;
    logic vsync_q,      vsync_d;
    logic video_on_q,   video_on_d;
    logic line_tick_q,  line_tick_d;
    logic frame_tick_q, frame_tick_d;

    contador_mod #(.N(H_TOTAL), .W(CNT_W)) u_cnt_h (
        .clk          (clk),
        .reset        (reset),
        .en_i         (1'b1),
        .count_o      (x_q),
        .count_next_c (x_next),
        .wrap_c       (h_wrap)
    );

    contador_mod #(.N(V_TOTAL), .W(CNT_W)) u_cnt_v (
        .clk          (clk),
        .reset        (reset),
        .en_i         (h_wrap),
        .count_o      (y_q),
        .count_next_c (y_next),
        .wrap_c       (v_wrap)
    );

    // Outputs are decoded from the counters' next values so that, once
    // registered, they describe the pixel the counters present in that cycle.
    always_comb begin
        hsync_d      = !((x_next >= HS_START) && (x_next <= HS_END));
        vsync_d      = !((y_next >= VS_START) && (y_next <= VS_END));
        video_on_d   = (x_next < H_VIS) && (y_next < V_VIS);
        line_tick_d  = h_wrap;
        frame_tick_d = h_wrap && v_wrap;
    end

    // Reset values match the parked position (last pixel of the frame).
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            video_on_q   <= 1'b0;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vga.pixel_x    = x_q;
    assign vga.pixel_y    = y_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.video_on   = video_on_q;
    assign vga.line_tick  = line_tick_q;
    assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sincronizador_vga.sv
// Bench for sincronizador_vga: a default-timing instance and a reduced-timing
// instance (25 x 17 counts) share clock and reset. The driver pushes expected
// outputs into queues; a negedge monitor pops and compares.
module tb_sincronizador_vga;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       lt;
        logic       ft;
    } obs_t;

    typedef struct {
        bit   sml;
        obs_t e;
        int   tag;
    } dir_t;

    // Reduced timing: H 16+2+4+3 = 25, V 10+2+2+3 = 17, hsync 18..21, vsync 12..13.
    localparam int SH_D = 16, SH_F = 2, SH_S = 4, SH_B = 3;
    localparam int SV_D = 10, SV_F = 2, SV_S = 2, SV_B = 3;
    localparam int S_HT = 25, S_VT = 17;
    localparam int D_HT = 800, D_VT = 525;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    sincronizador_vga_if vga_def ();
    sincronizador_vga_if vga_sml ();

    sincronizador_vga u_def (
        .clk   (clk),
        .reset (reset),
        .vga   (vga_def)
    );

    sincronizador_vga #(
        .H_DISPLAY (SH_D), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
        .V_DISPLAY (SV_D), .V_FRONT (SV_F), .V_SYNC (SV_S), .V_BACK (SV_B)
    ) u_sml (
        .clk   (clk),
        .reset (reset),
        .vga   (vga_sml)
    );

    int n_cmp = 0;
    int n_bad = 0;

    obs_t q_def[$];
    obs_t q_sml[$];
    dir_t q_dir[$];

    bit meas_en = 1'b0;

    function automatic obs_t mk(input int x, input int y, input bit hs, input bit vs,
                               input bit vo, input bit lt, input bit ft);
        obs_t o;
        o.x  = 10'(x);
        o.y  = 10'(y);
        o.hs = hs;
        o.vs = vs;
        o.vo = vo;
        o.lt = lt;
        o.ft = ft;
        return o;
    endfunction

    // Reference decode of the outputs from a pixel position.
    function automatic obs_t ref_obs(input int x, input int y,
                                     input int hd, input int hf, input int hsw,
                                     input int vd, input int vf, input int vsw);
        return mk(x, y,
                  !(x >= hd + hf && x < hd + hf + hsw),
                  !(y >= vd + vf && y < vd + vf + vsw),
                  (x < hd) && (y < vd),
                  x == 0,
                  x == 0 && y == 0);
    endfunction

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b vo=%b lt=%b ft=%b, required x=%0d y=%0d hs=%b vs=%b vo=%b lt=%b ft=%b",
                     name, act.x, act.y, act.hs, act.vs, act.vo, act.lt, act.ft,
                     exp.x, exp.y, exp.hs, exp.vs, exp.vo, exp.lt, exp.ft);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // ---------------- driver + reference model ----------------
    int mx_d, my_d, mx_s, my_s;

    task automatic adv(inout int x, inout int y, input int ht, input int vt, input logic r);
        if (r) begin
            x = ht - 1;
            y = vt - 1;
        end else if (x == ht - 1) begin
            x = 0;
            y = (y == vt - 1) ? 0 : y + 1;
        end else begin
            x = x + 1;
        end
    endtask

    task automatic step(input logic r);
        reset = r;
        @(posedge clk);
        #1;
        adv(mx_d, my_d, D_HT, D_VT, r);
        adv(mx_s, my_s, S_HT, S_VT, r);
        q_def.push_back(ref_obs(mx_d, my_d, 640, 16, 96, 480, 10, 2));
        q_sml.push_back(ref_obs(mx_s, my_s, SH_D, SH_F, SH_S, SV_D, SV_F, SV_S));
    endtask

    task automatic dir(input bit sml, input obs_t e, input int tag);
        dir_t d;
        d.sml = sml;
        d.e   = e;
        d.tag = tag;
        q_dir.push_back(d);
    endtask

    initial begin
        repeat (3) step(1'b1);
        dir(0, mk(799, 524, 1, 1, 0, 0, 0), 0);
        dir(1, mk(24, 16, 1, 1, 0, 0, 0), 1);

        step(1'b0);
        dir(0, mk(0, 0, 1, 1, 1, 1, 1), 2);
        dir(1, mk(0, 0, 1, 1, 1, 1, 1), 3);
        meas_en = 1'b1;

        for (int n = 1; n <= 2045; n++) begin
            step(1'b0);
            case (n)
                249:  dir(1, mk(24, 9, 1, 1, 0, 0, 0), 4);
                250:  dir(1, mk(0, 10, 1, 1, 0, 1, 0), 5);
                424:  dir(1, mk(24, 16, 1, 1, 0, 0, 0), 6);
                425:  dir(1, mk(0, 0, 1, 1, 1, 1, 1), 7);
                639:  dir(0, mk(639, 0, 1, 1, 1, 0, 0), 8);
                640:  dir(0, mk(640, 0, 1, 1, 0, 0, 0), 9);
                656:  dir(0, mk(656, 0, 0, 1, 0, 0, 0), 10);
                751:  dir(0, mk(751, 0, 0, 1, 0, 0, 0), 11);
                752:  dir(0, mk(752, 0, 1, 1, 0, 0, 0), 12);
                799:  dir(0, mk(799, 0, 1, 1, 0, 0, 0), 13);
                800:  dir(0, mk(0, 1, 1, 1, 1, 1, 0), 14);
                2000: meas_en = 1'b0;
                2045: dir(1, mk(20, 13, 0, 0, 0, 0, 0), 15);
                default: ;
            endcase
        end

        // Mid-frame reset with both syncs of the reduced instance low.
        step(1'b1);
        dir(0, mk(799, 524, 1, 1, 0, 0, 0), 16);
        dir(1, mk(24, 16, 1, 1, 0, 0, 0), 17);
        step(1'b0);
        dir(0, mk(0, 0, 1, 1, 1, 1, 1), 18);
        dir(1, mk(0, 0, 1, 1, 1, 1, 1), 19);
        repeat (30) step(1'b0);

        @(negedge clk);
        #1;
        chk_int("queues_drained", q_def.size() + q_sml.size() + q_dir.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion before 500000");
        $fatal(1);
    end

    // ---------------- monitor ----------------
    int   cyc = 0;
    obs_t a_def_prev, a_sml_prev;
    int   hs_run = 0, vs_run = 0;
    int   last_lt = -1, last_ft = -1;
    bit   have_prev = 1'b0;

    always @(negedge clk) begin
        obs_t a_def, a_sml, e;
        dir_t d;
        a_def = mk(int'(vga_def.pixel_x), int'(vga_def.pixel_y), vga_def.hsync, vga_def.vsync,
                   vga_def.video_on, vga_def.line_tick, vga_def.frame_tick);
        a_sml = mk(int'(vga_sml.pixel_x), int'(vga_sml.pixel_y), vga_sml.hsync, vga_sml.vsync,
                   vga_sml.video_on, vga_sml.line_tick, vga_sml.frame_tick);

        if (q_def.size() > 0) begin
            e = q_def.pop_front();
            chk("model_def", a_def, e);
        end
        if (q_sml.size() > 0) begin
            e = q_sml.pop_front();
            chk("model_sml", a_sml, e);
        end
        while (q_dir.size() > 0) begin
            d = q_dir.pop_front();
            chk($sformatf("vec%0d_%s", d.tag, d.sml ? "sml" : "def"), d.sml ? a_sml : a_def, d.e);
        end

        // Run-length and period checks with hand-computed constants.
        if (meas_en) begin
            if (have_prev) begin
                if (a_def_prev.hs && !a_def.hs) chk_int("hsync_fall_x", int'(a_def.x), 656);
                if (!a_def_prev.hs && a_def.hs) chk_int("hsync_low_len", hs_run, 96);
                if (a_def_prev.vo && !a_def.vo) chk_int("video_off_x", int'(a_def.x), 640);
                if (a_sml_prev.vs && !a_sml.vs)
                    chk_int("vsync_fall_pos", int'(a_sml.y) * 100 + int'(a_sml.x), 1200);
                if (!a_sml_prev.vs && a_sml.vs) chk_int("vsync_low_len", vs_run, 50);
            end
            hs_run = a_def.hs ? 0 : hs_run + 1;
            vs_run = a_sml.vs ? 0 : vs_run + 1;
            if (a_def.lt) begin
                if (last_lt >= 0) chk_int("line_tick_period", cyc - last_lt, 800);
                last_lt = cyc;
            end
            if (a_sml.ft) begin
                if (last_ft >= 0) chk_int("frame_tick_period", cyc - last_ft, 425);
                last_ft = cyc;
            end
            a_def_prev = a_def;
            a_sml_prev = a_sml;
            have_prev  = 1'b1;
            cyc++;
        end
    end

endmodule
